// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types, encodings and byte helpers for the byte-wide
// RAM sequencer. Optional round-robin arbitration is selected in mem_ctrl
// by the macro MEM_CTRL_RR_ARB_EN.
package mem_ctrl_pkg;

    // Access size selector driven by the MEM stage
    typedef logic [1:0] mem_sel_t;
    localparam mem_sel_t MEM_BYTE = 2'b00;
    localparam mem_sel_t MEM_HALF = 2'b01;
    localparam mem_sel_t MEM_WORD = 2'b10;

    // Sequencer states (3-bit encoding)
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [7:0]  ZERO_BYTE  = 8'h00;
    localparam logic        RST_ENABLE = 1'b1;

    // Identity of the last winner of a contested grant
    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    // Number of RAM bytes moved for a MEM access of the given size
    function automatic logic [2:0] sel_nbytes(input mem_sel_t sel);
        case (sel)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    // Little-endian byte lane extract
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

    // Little-endian byte lane insert
    function automatic logic [31:0] set_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[8*idx +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// mem_ctrl_ext: combinational sign/zero extender for byte, half and word
// loads. Only the low bytes selected by sel_i are meaningful on data_i.
module mem_ctrl_ext
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        sel_i,
    input  logic              sign_i,
    output logic [DATA_W-1:0] data_o
);

    // Replicate the top bit of the loaded size, or zero-fill
    always_comb begin
        data_o = data_i;
        case (sel_i)
            MEM_BYTE: data_o = {{(DATA_W-8){sign_i & data_i[7]}}, data_i[7:0]};
            MEM_HALF: data_o = {{(DATA_W-16){sign_i & data_i[15]}}, data_i[15:0]};
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte sequencer for the single byte-wide RAM port
// shared by instruction fetch and the MEM stage. All RAM-side and result
// outputs are registered. Define MEM_CTRL_RR_ARB_EN for round-robin
// arbitration on contested grants; otherwise MEM always beats IF.
//
// Handshake: if_req / mem_req are levels held until the matching done pulse;
// the requester drops req in the done cycle, since the sequencer samples
// requests again in the IDLE cycle that follows DONE.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_sel,
    input  logic              mem_load_sign,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_we,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;        // cycle index within the access, minus one
    logic [2:0]        nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    mem_sel_t          sel_q, sel_d;
    logic              sign_q, sign_d;
    logic              flushed_q, flushed_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_we_q, ram_we_d;
    logic              busy_q, busy_d;
    logic [2:0]        cnt_m1;
    logic [DATA_W-1:0] ext_data;
    logic              if_eff, grant_mem, grant_if;

    // Flush in IDLE masks the fetch request before arbitration
    assign if_eff = if_req & ~if_flush;

`ifdef MEM_CTRL_RR_ARB_EN
    logic last_grant_q, last_grant_d;
    logic contested;

    // Contested grant goes to whichever port lost the previous contest
    always_comb begin
        contested    = mem_req & if_eff;
        grant_mem    = (state_q == IDLE) & mem_req & (~contested | (last_grant_q == GRANT_IF));
        grant_if     = (state_q == IDLE) & if_eff & ~grant_mem;
        last_grant_d = last_grant_q;
        if ((state_q == IDLE) && contested) begin
            last_grant_d = grant_mem ? GRANT_MEM : GRANT_IF;
        end
    end

    // Round-robin history register
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            last_grant_q <= GRANT_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: MEM beats IF
    always_comb begin
        grant_mem = (state_q == IDLE) & mem_req;
        grant_if  = (state_q == IDLE) & if_eff & ~mem_req;
    end
`endif

    assign cnt_m1 = cnt_q - 3'd1;

    mem_ctrl_ext #(.DATA_W(DATA_W)) u_ext (
        .data_i (buf_d),
        .sel_i  (sel_q),
        .sign_i (sign_q),
        .data_o (ext_data)
    );

    // Next-state, byte sequencing and registered output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        sign_d      = sign_q;
        flushed_d   = flushed_q;
        buf_d       = buf_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        ram_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    cnt_d      = 3'd0;
                    nbytes_d   = sel_nbytes(mem_sel);
                    base_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    sel_d      = mem_sel;
                    sign_d     = mem_load_sign;
                    flushed_d  = 1'b0;
                    ram_addr_d = mem_addr;
                    if (mem_we) begin
                        state_d    = MEM_WR;
                        ram_we_d   = 1'b1;
                        ram_dout_d = get_byte(mem_wdata, 2'd0);
                    end else begin
                        state_d = MEM_RD;
                    end
                end else if (grant_if) begin
                    state_d    = IF_RD;
                    cnt_d      = 3'd0;
                    nbytes_d   = 3'd4;
                    base_d     = if_addr;
                    flushed_d  = 1'b0;
                    ram_addr_d = if_addr;
                end
            end
            IF_RD, MEM_RD: begin
                cnt_d = cnt_q + 3'd1;
                // ram_din carries the byte addressed one cycle earlier
                if (cnt_q != 3'd0) begin
                    buf_d = set_byte(buf_q, cnt_m1[1:0], ram_din);
                end
                if (state_q == IF_RD) begin
                    flushed_d = flushed_q | if_flush;
                end
                if (cnt_d < nbytes_q) begin
                    ram_addr_d = base_q + ADDR_W'(cnt_d);
                end
                if (cnt_q == nbytes_q) begin
                    if (state_q == IF_RD) begin
                        if (flushed_q || if_flush) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DONE;
                            if_done_d = 1'b1;
                            if_inst_d = buf_d;
                        end
                    end else begin
                        state_d     = DONE;
                        mem_done_d  = 1'b1;
                        mem_rdata_d = ext_data;
                    end
                end
            end
            MEM_WR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_d < nbytes_q) begin
                    ram_addr_d = base_q + ADDR_W'(cnt_d);
                    ram_dout_d = get_byte(wdata_q, cnt_d[1:0]);
                    ram_we_d   = 1'b1;
                end else begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, access context and output registers
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            base_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= MEM_BYTE;
            sign_q      <= 1'b0;
            flushed_q   <= 1'b0;
            buf_q       <= ZERO_WORD;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_dout_q  <= ZERO_BYTE;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            sign_q      <= sign_d;
            flushed_q   <= flushed_d;
            buf_q       <= buf_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_inst   = if_inst_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_dout  = ram_dout_q;
    assign ram_we    = ram_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl. A small read-only byte table
// answers RAM reads one cycle after the address; stores are checked on the
// RAM pins cycle by cycle.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_sel;
  logic        mem_load_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din = 8'h00;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_flush      (if_flush),
    .if_done       (if_done),
    .if_inst       (if_inst),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_sel       (mem_sel),
    .mem_load_sign (mem_load_sign),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_done      (mem_done),
    .mem_rdata     (mem_rdata),
    .ram_din       (ram_din),
    .ram_addr      (ram_addr),
    .ram_dout      (ram_dout),
    .ram_we        (ram_we),
    .busy          (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM contents seen by reads
  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0102: return 8'h10;
      32'h0000_0103: return 8'h00;
      32'h0000_2000: return 8'h80;
      32'h0000_3000: return 8'h34;
      32'h0000_3001: return 8'h92;
      32'h0000_3002: return 8'h56;
      32'h0000_3003: return 8'hF8;
      32'hFFFF_FFFF: return 8'hAA;
      32'h0000_0000: return 8'hBB;
      32'h0000_0001: return 8'hCC;
      32'h0000_0002: return 8'hDD;
      default:       return 8'h00;
    endcase
  endfunction

  // synchronous read: data valid the cycle after its address
  always @(posedge clk) ram_din <= rom(ram_addr);

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic we, input logic [1:0] sel, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
    mem_req       = 1'b1;
    mem_we        = we;
    mem_sel       = sel;
    mem_load_sign = sign;
    mem_addr      = addr;
    mem_wdata     = wdata;
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_if_done"},  {31'd0, if_done},  32'd0);
    check({tag, "_mem_done"}, {31'd0, mem_done}, 32'd0);
    check({tag, "_if_inst"},  if_inst,           32'd0);
    check({tag, "_mem_rdata"}, mem_rdata,        32'd0);
    check({tag, "_ram_addr"}, ram_addr,          32'd0);
    check({tag, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
    check({tag, "_ram_we"},   {31'd0, ram_we},   32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
  endtask

  logic [31:0] st_addr [4];
  logic [7:0]  st_data [4];

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 2'b00; mem_load_sign = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    st_addr = '{32'h40, 32'h41, 32'h42, 32'h43};
    st_data = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // word fetch from 0x100 (cycle 0 = this idle cycle)
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("fetch_addr_c%0d", k + 1), ram_addr, 32'h100 + 32'(k));
      check($sformatf("fetch_we_c%0d", k + 1), {31'd0, ram_we}, 32'd0);
    end
    tick();
    check("fetch_done_c5", {31'd0, if_done}, 32'd0);
    tick();
    check("fetch_done_c6", {31'd0, if_done}, 32'd1);
    check("fetch_inst", if_inst, 32'h0010_0513);
    if_req = 1'b0;
    tick();
    check("fetch_idle_busy", {31'd0, busy}, 32'd0);
    check("fetch_idle_done", {31'd0, if_done}, 32'd0);
    check("fetch_addr_hold", ram_addr, 32'h103);

    // signed byte load from 0x2000
    set_mem(1'b0, 2'b00, 1'b1, 32'h2000, 32'h0);
    tick();
    check("lb_addr", ram_addr, 32'h2000);
    tick();
    check("lb_done_c2", {31'd0, mem_done}, 32'd0);
    tick();
    check("lb_done_c3", {31'd0, mem_done}, 32'd1);
    check("lb_rdata", mem_rdata, 32'hFFFF_FF80);
    mem_req = 1'b0;
    tick();

    // unsigned byte load from 0x2000
    set_mem(1'b0, 2'b00, 1'b0, 32'h2000, 32'h0);
    tick(); tick(); tick();
    check("lbu_done", {31'd0, mem_done}, 32'd1);
    check("lbu_rdata", mem_rdata, 32'h0000_0080);
    mem_req = 1'b0;
    tick();

    // signed half load from 0x3000
    set_mem(1'b0, 2'b01, 1'b1, 32'h3000, 32'h0);
    tick(); tick(); tick(); tick();
    check("lh_done", {31'd0, mem_done}, 32'd1);
    check("lh_rdata", mem_rdata, 32'hFFFF_9234);
    mem_req = 1'b0;
    tick();

    // unsigned half load from 0x3000
    set_mem(1'b0, 2'b01, 1'b0, 32'h3000, 32'h0);
    tick(); tick(); tick(); tick();
    check("lhu_rdata", mem_rdata, 32'h0000_9234);
    mem_req = 1'b0;
    tick();

    // word load from 0x3000
    set_mem(1'b0, 2'b10, 1'b1, 32'h3000, 32'h0);
    for (int c = 0; c < 6; c++) tick();
    check("lw_done", {31'd0, mem_done}, 32'd1);
    check("lw_rdata", mem_rdata, 32'hF856_9234);
    mem_req = 1'b0;
    tick();

    // word store 0xDEADBEEF to 0x40
    set_mem(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("sw_we_c%0d", k + 1), {31'd0, ram_we}, 32'd1);
      check($sformatf("sw_addr_c%0d", k + 1), ram_addr, st_addr[k]);
      check($sformatf("sw_dout_c%0d", k + 1), {24'd0, ram_dout}, {24'd0, st_data[k]});
      check($sformatf("sw_done_c%0d", k + 1), {31'd0, mem_done}, 32'd0);
    end
    tick();
    check("sw_done_c5", {31'd0, mem_done}, 32'd1);
    check("sw_we_c5", {31'd0, ram_we}, 32'd0);
    mem_req = 1'b0;
    tick();

    // contention: MEM byte load vs fetch, MEM served first
    if_req = 1'b1; if_addr = 32'h100;
    set_mem(1'b0, 2'b00, 1'b1, 32'h2000, 32'h0);
    tick();
    check("cont1_addr", ram_addr, 32'h2000);
    tick(); tick();
    check("cont1_mem_done", {31'd0, mem_done}, 32'd1);
    check("cont1_rdata", mem_rdata, 32'hFFFF_FF80);
    mem_req = 1'b0;
    tick();
    tick();
    check("cont1_fetch_addr", ram_addr, 32'h100);
    for (int c = 0; c < 5; c++) tick();
    check("cont1_if_done", {31'd0, if_done}, 32'd1);
    check("cont1_if_inst", if_inst, 32'h0010_0513);
    if_req = 1'b0;
    tick();

    // second contention: byte store vs fetch at 0xFFFFFFFF (address wraps)
    if_req = 1'b1; if_addr = 32'hFFFF_FFFF;
    set_mem(1'b1, 2'b00, 1'b0, 32'h40, 32'h0000_005A);
`ifdef MEM_CTRL_RR_ARB_EN
    tick();
    check("cont2_rr_we", {31'd0, ram_we}, 32'd0);
    check("cont2_rr_addr", ram_addr, 32'hFFFF_FFFF);
    tick();
    check("cont2_rr_wrap", ram_addr, 32'h0000_0000);
    for (int c = 0; c < 4; c++) tick();
    check("cont2_rr_if_done", {31'd0, if_done}, 32'd1);
    check("cont2_rr_if_inst", if_inst, 32'hDDCC_BBAA);
    if_req = 1'b0;
    tick(); tick();
    check("cont2_rr_st_we", {31'd0, ram_we}, 32'd1);
    check("cont2_rr_st_dout", {24'd0, ram_dout}, 32'h5A);
    tick();
    check("cont2_rr_mem_done", {31'd0, mem_done}, 32'd1);
    mem_req = 1'b0;
    tick();
`else
    tick();
    check("cont2_st_we", {31'd0, ram_we}, 32'd1);
    check("cont2_st_addr", ram_addr, 32'h40);
    check("cont2_st_dout", {24'd0, ram_dout}, 32'h5A);
    tick();
    check("cont2_mem_done", {31'd0, mem_done}, 32'd1);
    check("cont2_st_we_off", {31'd0, ram_we}, 32'd0);
    mem_req = 1'b0;
    tick(); tick();
    check("cont2_fetch_addr", ram_addr, 32'hFFFF_FFFF);
    tick();
    check("cont2_wrap", ram_addr, 32'h0000_0000);
    for (int c = 0; c < 4; c++) tick();
    check("cont2_if_done", {31'd0, if_done}, 32'd1);
    check("cont2_if_inst", if_inst, 32'hDDCC_BBAA);
    if_req = 1'b0;
    tick();
`endif

    // flush during cycle 2 of a fetch: no if_done, then a MEM access proceeds
    if_req = 1'b1; if_addr = 32'h100;
    tick(); tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    check("flush_busy_c3", {31'd0, busy}, 32'd1);
    tick(); tick(); tick();
    check("flush_no_done_c6", {31'd0, if_done}, 32'd0);
    tick();
    check("flush_no_done_c7", {31'd0, if_done}, 32'd0);
    check("flush_busy_c7", {31'd0, busy}, 32'd0);
    set_mem(1'b0, 2'b00, 1'b0, 32'h2000, 32'h0);
    tick();
    check("flush_mem_addr", ram_addr, 32'h2000);
    tick(); tick();
    check("flush_mem_done", {31'd0, mem_done}, 32'd1);
    check("flush_mem_rdata", mem_rdata, 32'h0000_0080);
    mem_req = 1'b0;
    tick();

    // flush in IDLE suppresses the fetch grant
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h100;
    tick();
    check("idle_flush_busy", {31'd0, busy}, 32'd0);
    if_req = 1'b0; if_flush = 1'b0;
    tick();

    // reset during cycle 2 of a word store
    set_mem(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
    tick();
    tick();
    check("rst_st_we_c2", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    tick();
    check_idle_outputs("rst_mid");
    rst = 1'b0; mem_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rst_after_done_%0d", c), {31'd0, mem_done}, 32'd0);
      check($sformatf("rst_after_busy_%0d", c), {31'd0, busy}, 32'd0);
    end

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
